// File: rtl/uart_rx_fifo_if.sv
// Byte stream between UART receiver, receive FIFO and downstream consumer.
// Push side is a one-cycle rdata_ready pulse; pop side is valid/ready.
interface uart_rx_fifo_if;
    logic [7:0] rdata;
    logic       rdata_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output rdata, rdata_ready, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  rdata, rdata_ready, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART RX, first-word-fall-through, with overflow and framing-error stats.
// Latency: byte pushed in cycle N is presented with out_valid from cycle N+1 (no empty bypass).
// Backpressure: out_ready stalls the head; pushes into a full FIFO are dropped unless a pop frees the slot.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_if.slave     bus,
    input  logic              ferr,
    input  logic              clr,
    output logic [AW:0]       count,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        ferr_count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          ferr_q;
    logic          pop;
    logic          push;
    logic          drop;

    // Status comes only from registered count so nothing combinational reaches the consumer.
    assign bus.out_valid = (count != '0);
    assign full          = (count == (AW+1)'(DEPTH));
    assign bus.out_data  = mem[rd_ptr];

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.rdata_ready & (~full | pop);
    assign drop = bus.rdata_ready & full & ~pop;

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= bus.rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (clr)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

    // ferr_q keeps sampling through clr so a level already high is not counted again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ferr_q <= 1'b0;
        else
            ferr_q <= ferr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ferr_count <= '0;
        else if (clr)
            ferr_count <= '0;
        else if (ferr && !ferr_q && ferr_count != 8'hFF)
            ferr_count <= ferr_count + 8'd1;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16) with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       ferr;
    logic       clr;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] ferr_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_rx_fifo_if bus();

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ferr       (ferr),
        .clr        (clr),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .ferr_count (ferr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rdata       = b;
        bus.rdata_ready = 1'b1;
        cyc();
        bus.rdata_ready = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk(tag, 32'(bus.out_data), 32'(exp));
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    logic [31:0] pat;
    logic [7:0]  q[$];
    int          idx;
    int          got_n;
    int          mcnt;
    bit          dp;
    bit          dq;

    initial begin
        rst             = 1'b1;
        ferr            = 1'b0;
        clr             = 1'b0;
        bus.rdata       = 8'h00;
        bus.rdata_ready = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ferr", 32'(ferr_count), 32'd0);
        rst = 1'b0;
        cyc();

        // single byte
        push(8'hA5);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data", 32'(bus.out_data), 32'hA5);
        chk("t1_count", 32'(count), 32'd1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t1_empty", 32'(bus.out_valid), 32'd0);
        chk("t1_count0", 32'(count), 32'd0);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        chk("t2_ovf0", 32'(overflow), 32'd0);
        push(8'h10);
        chk("t2_ovf1", 32'(overflow), 32'd1);
        chk("t2_count_ovf", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) pop_chk("t2_drain", 8'(i));
        chk("t2_no_extra", 32'(bus.out_valid), 32'd0);

        // full with simultaneous push and pop
        do_clr();
        chk("t3_clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t3_head", 32'(bus.out_data), 32'h00);
        bus.rdata       = 8'h55;
        bus.rdata_ready = 1'b1;
        bus.out_ready   = 1'b1;
        cyc();
        bus.rdata_ready = 1'b0;
        bus.out_ready   = 1'b0;
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("t3_drain", 8'(i));
        pop_chk("t3_last", 8'h55);
        chk("t3_empty", 32'(bus.out_valid), 32'd0);

        // wrap-around with a fixed irregular out_ready pattern
        pat   = 32'hA6C3_5B91;
        idx   = 0;
        got_n = 0;
        mcnt  = 0;
        for (int c = 0; c < 600 && got_n < 40; c++) begin
            dp = (idx < 40) && (mcnt < 16);
            dq = (mcnt > 0) && pat[c % 32];
            bus.rdata       = idx[7:0];
            bus.rdata_ready = dp;
            bus.out_ready   = dq;
            @(negedge clk);
            chk("t4_count", 32'(count), 32'(mcnt));
            if (dq) chk("t4_data", 32'(bus.out_data), 32'(q[0]));
            @(posedge clk);
            #1;
            if (dp) begin
                q.push_back(idx[7:0]);
                idx++;
                mcnt++;
            end
            if (dq) begin
                void'(q.pop_front());
                got_n++;
                mcnt--;
            end
        end
        bus.rdata_ready = 1'b0;
        bus.out_ready   = 1'b0;
        chk("t4_done", 32'(got_n), 32'd40);
        chk("t4_empty", 32'(count), 32'd0);
        chk("t4_ovf", 32'(overflow), 32'd0);

        // ferr edge counting and saturation
        do_clr();
        ferr = 1'b1; repeat (2) cyc();
        ferr = 1'b0; repeat (2) cyc();
        ferr = 1'b1; repeat (50) cyc();
        ferr = 1'b0; repeat (2) cyc();
        ferr = 1'b1; cyc();
        ferr = 1'b0; cyc();
        chk("t5_ferr3", 32'(ferr_count), 32'd3);
        for (int i = 0; i < 300; i++) begin
            ferr = 1'b1; cyc();
            ferr = 1'b0; cyc();
        end
        chk("t5_ferr_sat", 32'(ferr_count), 32'd255);

        // clr with pending push, ferr held high across clr
        do_clr();
        chk("t6_ferr_clr", 32'(ferr_count), 32'd0);
        for (int i = 0; i < 16; i++) push(8'(i + 8'h20));
        push(8'h99);
        for (int i = 0; i < 11; i++) pop_chk("t6_pop", 8'(i + 8'h20));
        ferr = 1'b1; cyc();
        ferr = 1'b0; cyc();
        ferr = 1'b1; cyc();
        chk("t6_pre_count", 32'(count), 32'd5);
        chk("t6_pre_ovf", 32'(overflow), 32'd1);
        chk("t6_pre_ferr", 32'(ferr_count), 32'd2);
        clr             = 1'b1;
        bus.rdata       = 8'hEE;
        bus.rdata_ready = 1'b1;
        cyc();
        clr             = 1'b0;
        bus.rdata_ready = 1'b0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_ferr", 32'(ferr_count), 32'd0);
        repeat (2) cyc();
        chk("t6_ferr_held", 32'(ferr_count), 32'd0);
        ferr = 1'b0;
        push(8'h3C);
        chk("t6_after_data", 32'(bus.out_data), 32'h3C);
        chk("t6_after_count", 32'(count), 32'd1);

        // asynchronous reset mid-stream
        ferr = 1'b1; cyc();
        ferr = 1'b0;
        for (int i = 0; i < 15; i++) push(8'(i + 8'h40));
        push(8'hAA);
        chk("t7_pre_full", 32'(full), 32'd1);
        chk("t7_pre_ovf", 32'(overflow), 32'd1);
        chk("t7_pre_ferr", 32'(ferr_count), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t7_count", 32'(count), 32'd0);
        chk("t7_valid", 32'(bus.out_valid), 32'd0);
        chk("t7_full", 32'(full), 32'd0);
        chk("t7_ovf", 32'(overflow), 32'd0);
        chk("t7_ferr", 32'(ferr_count), 32'd0);
        cyc();
        rst = 1'b0;
        push(8'h77);
        chk("t7_first_data", 32'(bus.out_data), 32'h77);
        chk("t7_first_count", 32'(count), 32'd1);
        pop_chk("t7_first_pop", 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It captures each received byte, which arrives as a one-cycle rdata_ready pulse qualified by rdata. It holds up to DEPTH bytes and presents them first-word-fall-through on a valid/ready interface to the consumer, such as a loopback transmitter or host logic. It also reports overflow and counts framing-error events signalled by the receiver's sticky ferr level.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high.
rdata  input  8  received byte; valid only in the cycle rdata_ready=1.
rdata_ready  input  1  one-cycle pulse from the receiver; push request.
ferr  input  1  framing-error level from the receiver; sticky there, may stay high indefinitely.
clr  input  1  synchronous flush and clear of status.
out_data  output  8  head byte; meaningful only while out_valid=1.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts the head byte when out_valid=1.
count  output  AW+1  number of stored bytes, 0..DEPTH.
full  output  1  count==DEPTH.
overflow  output  1  sticky: at least one byte dropped because the FIFO was full.
ferr_count  output  8  number of ferr rising edges, saturating at 255.

Behaviour:
- Reset (async, rst=1):
  - Pointers and count = 0; out_valid=0; full=0; overflow=0; ferr_count=0.
  - Internal ferr edge-detect register = 0.
  - Storage contents are don't-care; out_data is 0 or don't-care, and the bench must not check it while out_valid=0.
- Storage:
  - DEPTH x 8 register array; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH naturally.
  - count is tracked separately (AW+1 bits) to distinguish full from empty.
- pop = out_valid & out_ready.
- push_req = rdata_ready.
- push = push_req & (~full | pop).
  - A write into a full FIFO is accepted when a pop happens in the same cycle.
- Write path: on push, mem[wr_ptr] <= rdata and wr_ptr increments.
- Read path:
  - out_data = mem[rd_ptr], combinational from registered storage.
  - On pop, rd_ptr increments.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither occur.
- out_valid = (count != 0); full = (count == DEPTH). Both are derived from registered count, with no combinational path from inputs.
- Latency: a byte pushed in cycle N is visible with out_valid=1 from cycle N+1. There is no bypass when empty; push and pop in the same cycle while empty cannot occur.
- Overflow: push_req & full & ~pop → byte dropped, storage and pointers unchanged, overflow <= 1 (sticky).
- ferr edge detect:
  - ferr_q <= ferr every cycle.
  - On ferr & ~ferr_q, ferr_count increments unless already 255.
  - A held-high ferr counts once.
  - ferr does not block or alter pushes; the receiver simply issues no rdata_ready for a bad frame.
- clr (priority over everything except rst):
  - Pointers and count <= 0; overflow <= 0; ferr_count <= 0.
  - Any push_req or pop in that cycle is ignored, and the dropped push does not set overflow.
  - ferr_q still samples ferr, so an already-high ferr is not recounted after clr.
- Ordering: bytes are delivered exactly in arrival order. There is no duplication and no loss except the documented overflow drop.
- out_data must remain stable while out_valid=1 and out_ready=0, including when a push happens that cycle.
- Reset mid-operation: all stored bytes are discarded immediately. The first push after rst deasserts goes to entry 0.

Test Plan:
1. Single byte: push 0xA5 (rdata_ready pulse) with out_ready=0 → next cycle out_valid=1, out_data=0xA5, count=1. Then out_ready=1 for one cycle → out_valid=0, count=0.
2. Fill and overflow (DEPTH=16): push 0x00..0x0F with out_ready=0 → full=1, count=16, overflow=0. Push 0x10 → overflow=1, count=16. Drain → 0x00..0x0F in order; 0x10 never appears.
3. Full with simultaneous push/pop: at full, push 0x55 while out_ready=1 → count stays 16, overflow stays 0. 0x55 is the last byte drained after 0x01..0x0F.
4. Wrap-around: 40 bytes 0x00..0x27 pushed with a random out_ready pattern, never overflowing → output sequence identical, count never exceeds 16, pointers wrap without loss.
5. ferr counting: pulse ferr high for 3 separate windows (one window held high for 50 cycles) → ferr_count=3. Force 300 edges → ferr_count=255.
6. clr and reset: with count=5, overflow=1, ferr_count=2, assert clr together with rdata_ready → next cycle count=0, out_valid=0, overflow=0, ferr_count=0, byte not stored. Assert rst asynchronously mid-stream → outputs reach reset values before the next clock edge.
